// File: rtl/sr_arb_pkg.sv
// Shared types for the SR flag bank arbiter: size defaults, FSM states, latched command.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sr_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_NFLAG = 8;
    localparam int IDX_W_MAX = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_e;

    // idx is sized for the largest bank; smaller banks leave the upper bits zero
    typedef struct packed {
        logic                 s;
        logic                 r;
        logic [IDX_W_MAX-1:0] idx;
    } cmd_t;

    function automatic logic illegal_cmd(input cmd_t c);
        return c.s & c.r;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One SR flag held in a T-type flop: toggles when enabled and the S/R request disagrees with Q.
// Latency: new Q visible one cycle after the enabled edge.
// Backpressure: none; en is a single-cycle strobe from the bank controller.
module sr_flag_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_q;
    logic q_d;
    logic t;

    always_comb begin
        t   = (r & q_q) | (s & ~q_q);
        q_d = q_q ^ (en & t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter feeding set/reset commands into a bank of SR flags; SR_ARB_TOGGLE_CNT_EN adds toggle_cnt.
// Latency: grant in IDLE (comb ready), flag updated at the APPLY closing edge; one command per two cycles.
// Backpressure: req_ready is one-hot in IDLE only; requesters hold valid until granted or lose their turn.
module sr_bank_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int NFLAG = DEF_NFLAG
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_s,
    input  logic [NREQ-1:0]                 req_r,
    input  logic [NREQ*$clog2(NFLAG)-1:0]   req_idx,
    output logic [NREQ-1:0]                 req_ready,
    output logic [NFLAG-1:0]                flags,
    output logic [NFLAG-1:0]                flags_bar,
    output logic                            busy,
`ifdef SR_ARB_TOGGLE_CNT_EN
    output logic [7:0]                      toggle_cnt,
`endif
    output logic                            err
);

    localparam int IW = $clog2(NFLAG);
    localparam int PW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    cmd_t            cmd_q, cmd_d;
    logic            err_q, err_d;
    logic [PW-1:0]   win;
    logic            apply;
    logic [NFLAG-1:0] cell_en;

    // First valid requester at or after start, scanning upward with wrap.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [PW-1:0]   start);
        logic [PW-1:0] pick;
        logic [PW-1:0] c;
        logic          found;
        pick  = start;
        c     = start;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && v[c]) begin
                pick  = c;
                found = 1'b1;
            end
            c = (c == PW'(NREQ-1)) ? '0 : c + PW'(1);
        end
        return pick;
    endfunction

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cmd_d     = cmd_q;
        err_d     = err_q;
        req_ready = '0;
        apply     = 1'b0;
        win       = rr_pick(req_valid, rr_ptr_q);

        case (state_q)
            IDLE: begin
                // ready is held low while reset is asserted, even though state is already IDLE
                if (rst && (|req_valid)) begin
                    req_ready[win]      = 1'b1;
                    cmd_d.s             = req_s[win];
                    cmd_d.r             = req_r[win];
                    cmd_d.idx           = '0;
                    cmd_d.idx[IW-1:0]   = req_idx[win*IW +: IW];
                    rr_ptr_d            = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
                    state_d             = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                if (illegal_cmd(cmd_q)) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cmd_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cmd_q    <= cmd_d;
            err_q    <= err_d;
        end
    end

    // s=r=1 never reaches the cells; it only raises err
    for (genvar i = 0; i < NFLAG; i++) begin : g_cell
        assign cell_en[i] = apply && !illegal_cmd(cmd_q) && (cmd_q.idx == IDX_W_MAX'(i));

        sr_flag_cell u_cell (
            .clk   (clk),
            .rst_n (rst),
            .en    (cell_en[i]),
            .s     (cmd_q.s),
            .r     (cmd_q.r),
            .q     (flags[i])
        );
    end

`ifdef SR_ARB_TOGGLE_CNT_EN
    logic [7:0]       toggle_cnt_q, toggle_cnt_d;
    logic [NFLAG-1:0] flip_vec;

    always_comb begin
        flip_vec     = cell_en & (({NFLAG{cmd_q.r}} & flags) | ({NFLAG{cmd_q.s}} & ~flags));
        toggle_cnt_d = toggle_cnt_q;
        if ((|flip_vec) && (toggle_cnt_q != 8'hFF)) begin
            toggle_cnt_d = toggle_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            toggle_cnt_q <= 8'd0;
        end else begin
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign toggle_cnt = toggle_cnt_q;
`endif

    assign flags_bar = ~flags;
    assign busy      = (state_q == APPLY);
    assign err       = err_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: directed scenarios then random traffic against a set/reset model.
module tb_sr_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IW    = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_s = '0;
    logic [NREQ-1:0]      req_r = '0;
    logic [NREQ*IW-1:0]   req_idx = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NFLAG-1:0]     flags;
    logic [NFLAG-1:0]     flags_bar;
    logic                 busy;
    logic                 err;
`ifdef SR_ARB_TOGGLE_CNT_EN
    logic [7:0]           toggle_cnt;
`endif

    sr_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_s      (req_s),
        .req_r      (req_r),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .flags      (flags),
        .flags_bar  (flags_bar),
        .busy       (busy),
`ifdef SR_ARB_TOGGLE_CNT_EN
        .toggle_cnt (toggle_cnt),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  ready;
        logic             busy;
        logic [NFLAG-1:0] flags;
        logic             err;
        logic [7:0]       tcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    bit         m_apply = 0;
    int         m_rr    = 0;
    bit [7:0]   m_flags = '0;
    bit         m_err   = 0;
    int         m_tcnt  = 0;
    bit         m_s     = 0;
    bit         m_r     = 0;
    int         m_idx   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock of stimulus; expected outputs for this cycle go to the scoreboard.
    task automatic cycle(input bit rst_v, input bit [3:0] v, input bit [3:0] s,
                         input bit [3:0] r, input bit [11:0] idx);
        exp_t e;
        int   w;
        int   c;
        bit   old;
        @(posedge clk);
        #2;
        rst       = rst_v;
        req_valid = v;
        req_s     = s;
        req_r     = r;
        req_idx   = idx;
        e.ready = '0;
        if (!rst_v) begin
            m_apply = 0; m_rr = 0; m_flags = '0; m_err = 0; m_tcnt = 0;
            e.busy = 1'b0; e.flags = '0; e.err = 1'b0; e.tcnt = 8'd0;
        end else begin
            e.busy  = m_apply;
            e.flags = m_flags;
            e.err   = m_err;
            e.tcnt  = m_tcnt[7:0];
            if (m_apply) begin
                if (m_s && m_r) begin
                    m_err = 1;
                end else if (m_s || m_r) begin
                    old = m_flags[m_idx];
                    m_flags[m_idx] = m_s;
                    if (old != m_s && m_tcnt < 255) m_tcnt++;
                end
                m_apply = 0;
            end else if (v != 0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_rr + k) % NREQ;
                    if (w < 0 && v[c]) w = c;
                end
                e.ready = 4'(1 << w);
                m_s     = s[w];
                m_r     = r[w];
                m_idx   = int'(idx[w*IW +: IW]);
                m_rr    = (w + 1) % NREQ;
                m_apply = 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 4'h0, 4'h0, 4'h0, 12'h000);
    endtask

    task automatic do_reset();
        cycle(0, 4'h0, 4'h0, 4'h0, 12'h000);
    endtask

    // monitor: compares DUT outputs against the scoreboard once per cycle
    initial begin : mon
        exp_t          me;
        logic [7:0]    fb;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                fb = ~me.flags;
                chk("req_ready", 32'(req_ready), 32'(me.ready));
                chk("busy",      32'(busy),      32'(me.busy));
                chk("flags",     32'(flags),     32'(me.flags));
                chk("flags_bar", 32'(flags_bar), 32'(fb));
                chk("err",       32'(err),       32'(me.err));
`ifdef SR_ARB_TOGGLE_CNT_EN
                chk("toggle_cnt", 32'(toggle_cnt), 32'(me.tcnt));
`endif
            end
        end
    end

    initial begin
        bit [3:0]  rs, rr;
        bit        rv;
        do_reset();
        do_reset();

        // req0 sets idx3
        cycle(1, 4'b0001, 4'b0001, 4'b0000, 12'h003);
        idle(3);

        // all four valid continuously from rr_ptr 0: grants 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 10; k++)
            cycle(1, 4'hF, 4'hF, 4'h0, {3'd3, 3'd2, 3'd1, 3'd0});
        idle(2);

        // set idx5 twice
        do_reset();
        cycle(1, 4'b0001, 4'b0001, 4'b0000, 12'd5);
        idle(1);
        cycle(1, 4'b0001, 4'b0001, 4'b0000, 12'd5);
        idle(2);

        // req2 s=r=1 idx0, then legal commands keep err high
        do_reset();
        cycle(1, 4'b0100, 4'b0100, 4'b0100, 12'h000);
        idle(1);
        cycle(1, 4'b0100, 4'b0100, 4'b0000, 12'(1 << 6));
        idle(1);
        cycle(1, 4'b0001, 4'b0000, 4'b0001, 12'd1);
        idle(2);

        // reset during APPLY of set idx7
        do_reset();
        cycle(1, 4'b0001, 4'b0001, 4'b0000, 12'd7);
        do_reset();
        do_reset();
        idle(3);

        // req1 drops before grant while req3 is granted
        do_reset();
        cycle(1, 4'b0010, 4'b0010, 4'b0000, {3'd0, 3'd0, 3'd2, 3'd0});
        idle(1);
        cycle(1, 4'b1010, 4'b1010, 4'b0000, {3'd4, 3'd0, 3'd2, 3'd0});
        idle(2);
        cycle(1, 4'b1011, 4'b1011, 4'b0000, {3'd4, 3'd0, 3'd2, 3'd6});
        idle(2);

        // random traffic with occasional resets and illegal commands
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 79) != 0);
            rs = 4'($urandom);
            rr = 4'($urandom);
            if ($urandom_range(0, 7) != 0) rr = rr & ~rs;
            cycle(rv, 4'($urandom), rs, rr, 12'($urandom));
        end
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
